// File: rtl/fft_sample_loader_if.sv
// Upstream sample stream into the FFT sample loader: valid/ready handshake,
// one complex sample per beat, plus a synchronous flush of a partial frame.
interface fft_sample_loader_if;
   logic        in_valid;
   logic [15:0] in_re;
   logic [15:0] in_im;
   logic        in_ready;
   logic        flush;

   // Source side: presents samples and may abort a partial frame.
   modport master (
      output in_valid,
      output in_re,
      output in_im,
      output flush,
      input  in_ready
   );

   // Loader side: accepts samples while filling a frame.
   modport slave (
      input  in_valid,
      input  in_re,
      input  in_im,
      input  flush,
      output in_ready
   );
endinterface

// File: rtl/fft_sample_loader.sv
// Collects D_WIDTH complex samples into a frame buffer, pulses start to the
// downstream FFT, then holds the buffer stable for the FFT's busy window and
// pulses frame_done before refilling. All state updates on the falling edge
// of clk to line up with the FFT core.
module fft_sample_loader #(
   parameter int unsigned D_WIDTH     = 64,
   parameter int unsigned LOG_2_WIDTH = 6,
   parameter int unsigned BUSY_CYCLES = 192
) (
   input  logic                          clk,
   input  logic                          rst,
   fft_sample_loader_if.slave            up,
   output logic [D_WIDTH-1:0][15:0]      output_Re,
   output logic [D_WIDTH-1:0][15:0]      output_Im,
   output logic                          start,
   output logic                          frame_done,
   output logic [LOG_2_WIDTH-1:0]        wr_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FILL  = 3'd1;
   localparam logic [2:0] START = 3'd2;
   localparam logic [2:0] BUSY  = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   localparam logic [LOG_2_WIDTH-1:0] LAST_IDX  = LOG_2_WIDTH'(D_WIDTH - 1);
   localparam logic [7:0]             BUSY_LOAD = 8'(BUSY_CYCLES - 1);

   logic [2:0]                   state_q, state_d;
   logic [LOG_2_WIDTH-1:0]       wr_count_q, wr_count_d;
   logic [7:0]                   busy_cnt_q, busy_cnt_d;
   logic [D_WIDTH-1:0][15:0]     buf_re_q, buf_re_d;
   logic [D_WIDTH-1:0][15:0]     buf_im_q, buf_im_d;
   logic                         ready;
   logic                         handshake;

   assign ready     = (state_q == FILL);
   assign handshake = up.in_valid & ready;

   // Next-state: frame fill, launch, busy countdown and completion.
   always_comb begin
      state_d    = state_q;
      wr_count_d = wr_count_q;
      busy_cnt_d = busy_cnt_q;
      buf_re_d   = buf_re_q;
      buf_im_d   = buf_im_q;
      case (state_q)
         IDLE: state_d = FILL;
         FILL: begin
            // Flush beats a simultaneous final handshake, so no launch happens.
            if (up.flush) begin
               wr_count_d = '0;
            end else if (handshake) begin
               buf_re_d[wr_count_q] = up.in_re;
               buf_im_d[wr_count_q] = up.in_im;
               wr_count_d           = wr_count_q + 1'b1;
               if (wr_count_q == LAST_IDX) begin
                  state_d = START;
               end
            end
         end
         START: begin
            state_d    = BUSY;
            busy_cnt_d = BUSY_LOAD;
         end
         BUSY: begin
            if (busy_cnt_q == 8'd0) begin
               state_d = DONE;
            end else begin
               busy_cnt_d = busy_cnt_q - 8'd1;
            end
         end
         DONE:    state_d = FILL;
         default: state_d = IDLE;
      endcase
   end

   // State and frame buffer registers, falling-edge clocked, async active-low reset.
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         wr_count_q <= '0;
         busy_cnt_q <= '0;
         buf_re_q   <= '0;
         buf_im_q   <= '0;
      end else begin
         state_q    <= state_d;
         wr_count_q <= wr_count_d;
         busy_cnt_q <= busy_cnt_d;
         buf_re_q   <= buf_re_d;
         buf_im_q   <= buf_im_d;
      end
   end

   assign up.in_ready = ready;
   assign start       = (state_q == START);
   assign frame_done  = (state_q == DONE);
   assign wr_count    = wr_count_q;
   assign output_Re   = buf_re_q;
   assign output_Im   = buf_im_q;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Bench for fft_sample_loader: a 192-cycle-busy instance for the main scenarios
// and a 1-cycle-busy instance for back-to-back frames. Accepted samples are
// queued as they are driven and checked against the frame buffer at start.
module tb_fft_sample_loader;
   localparam int unsigned DW = 64;

   typedef struct {
      int          idx;
      logic [15:0] re;
      logic [15:0] im;
   } smp_t;

   logic clk;
   logic rst;

   fft_sample_loader_if if0 ();
   fft_sample_loader_if if1 ();

   logic [DW-1:0][15:0] re0, im0, re1, im1;
   logic                start0, done0, start1, done1;
   logic [5:0]          wrc0, wrc1;

   fft_sample_loader #(.D_WIDTH(64), .LOG_2_WIDTH(6), .BUSY_CYCLES(192)) u0 (
      .clk        (clk),
      .rst        (rst),
      .up         (if0),
      .output_Re  (re0),
      .output_Im  (im0),
      .start      (start0),
      .frame_done (done0),
      .wr_count   (wrc0)
   );

   fft_sample_loader #(.D_WIDTH(64), .LOG_2_WIDTH(6), .BUSY_CYCLES(1)) u1 (
      .clk        (clk),
      .rst        (rst),
      .up         (if1),
      .output_Re  (re1),
      .output_Im  (im1),
      .start      (start1),
      .frame_done (done1),
      .wr_count   (wrc1)
   );

   int          errors = 0;
   int          checks = 0;
   smp_t        sb_q[$];
   logic [15:0] exp_re[DW];
   logic [15:0] exp_im[DW];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case a scenario loses synchronisation with the DUT.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic push0(input int idx, input logic [15:0] re, input logic [15:0] im);
      smp_t s;
      s.idx = idx; s.re = re; s.im = im;
      sb_q.push_back(s);
      exp_re[idx] = re;
      exp_im[idx] = im;
   endtask

   task automatic test_reset();
      int nz;
      repeat (2) @(posedge clk);
      checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", if0.in_ready); end
      checks++; if (start0 !== 1'b0) begin errors++; $display("FAIL rst_start: got %b expected 0", start0); end
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b expected 0", done0); end
      checks++; if (wrc0 !== 6'd0) begin errors++; $display("FAIL rst_wr_count: got %0d expected 0", wrc0); end
      nz = 0;
      for (int k = 0; k < DW; k++) if (re0[k] !== 16'h0 || im0[k] !== 16'h0) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL rst_buffer: got %0d nonzero entries expected 0", nz); end
      rst = 1'b1;
      @(posedge clk);
      checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_to_fill: got in_ready=%b expected 1", if0.in_ready); end
      for (int k = 0; k < DW; k++) begin exp_re[k] = 16'h0; exp_im[k] = 16'h0; end
   endtask

   task automatic test_basic_frame();
      int   early;
      int   lat;
      int   extra;
      smp_t s;
      early = 0;
      for (int k = 0; k < DW; k++) begin
         if (start0) early++;
         if0.in_valid = 1'b1;
         if0.in_re    = 16'(k);
         if0.in_im    = 16'hFFFF - 16'(k) + 16'd1;
         push0(k, 16'(k), 16'hFFFF - 16'(k) + 16'd1);
         @(posedge clk);
      end
      if0.in_valid = 1'b0;
      checks++; if (start0 !== 1'b1) begin errors++; $display("FAIL basic_start: got %b expected 1", start0); end
      checks++; if (early !== 0) begin errors++; $display("FAIL basic_early_start: got %0d expected 0", early); end
      checks++; if (wrc0 !== 6'd0) begin errors++; $display("FAIL basic_wr_wrap: got %0d expected 0", wrc0); end
      checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_start: got %b expected 0", if0.in_ready); end
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         checks++;
         if (re0[s.idx] !== s.re || im0[s.idx] !== s.im) begin
            errors++;
            $display("FAIL basic_buf[%0d]: got %h/%h expected %h/%h", s.idx, re0[s.idx], im0[s.idx], s.re, s.im);
         end
      end
      lat = 0; extra = 0;
      for (int c = 1; c <= 400; c++) begin
         @(posedge clk);
         if (start0) extra++;
         if (done0) begin lat = c; break; end
      end
      checks++; if (lat !== 193) begin errors++; $display("FAIL basic_done_latency: got %0d expected 193", lat); end
      checks++; if (extra !== 0) begin errors++; $display("FAIL basic_single_start: got %0d extra expected 0", extra); end
      @(posedge clk);
      checks++; if (if0.in_ready !== 1'b1 || done0 !== 1'b0) begin errors++; $display("FAIL basic_refill: got ready=%b done=%b expected 1/0", if0.in_ready, done0); end
   endtask

   task automatic test_gapped_input();
      int          st;
      logic [5:0]  exp_cnt;
      smp_t        s;
      st = 0;
      for (int i = 0; i < 128; i++) begin
         exp_cnt = 6'((i + 1) / 2);
         checks++; if (wrc0 !== exp_cnt) begin errors++; $display("FAIL gap_wr_count[%0d]: got %0d expected %0d", i, wrc0, exp_cnt); end
         if (start0) begin
            st++;
            checks++; if (i !== 127) begin errors++; $display("FAIL gap_start_cycle: got %0d expected 127", i); end
            while (sb_q.size() > 0) begin
               s = sb_q.pop_front();
               checks++;
               if (re0[s.idx] !== s.re || im0[s.idx] !== s.im) begin
                  errors++;
                  $display("FAIL gap_buf[%0d]: got %h/%h expected %h/%h", s.idx, re0[s.idx], im0[s.idx], s.re, s.im);
               end
            end
         end
         if (i == 127) begin
            // START cycle: keep valid high with junk to show it is not taken.
            if0.in_valid = 1'b1;
            if0.in_re    = 16'($urandom);
            if0.in_im    = 16'($urandom);
         end else if (i % 2 == 0) begin
            if0.in_valid = 1'b1;
            if0.in_re    = 16'h1000 + 16'(i / 2);
            if0.in_im    = 16'h2000 + 16'(i / 2);
            push0(i / 2, 16'h1000 + 16'(i / 2), 16'h2000 + 16'(i / 2));
         end else begin
            if0.in_valid = 1'b0;
         end
         @(posedge clk);
      end
      checks++; if (st !== 1) begin errors++; $display("FAIL gap_start_count: got %0d expected 1", st); end
   endtask

   task automatic test_backpressure();
      int seen;
      int bad_rdy;
      int bad_cnt;
      int diff;
      seen = 0; bad_rdy = 0; bad_cnt = 0;
      for (int c = 0; c < 400; c++) begin
         if (if0.in_ready !== 1'b0) bad_rdy++;
         if (wrc0 !== 6'd0) bad_cnt++;
         if0.in_valid = 1'b1;
         if0.in_re    = 16'($urandom);
         if0.in_im    = 16'($urandom);
         if (done0) begin seen = 1; @(posedge clk); break; end
         @(posedge clk);
      end
      checks++; if (seen !== 1) begin errors++; $display("FAIL bp_frame_done: got %0d expected 1", seen); end
      checks++; if (bad_rdy !== 0) begin errors++; $display("FAIL bp_in_ready: got %0d high cycles expected 0", bad_rdy); end
      checks++; if (bad_cnt !== 0) begin errors++; $display("FAIL bp_wr_count: got %0d nonzero cycles expected 0", bad_cnt); end
      checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_refill: got %b expected 1", if0.in_ready); end
      if0.in_valid = 1'b0;
      @(posedge clk);
      checks++; if (wrc0 !== 6'd0) begin errors++; $display("FAIL bp_no_write: got %0d expected 0", wrc0); end
      diff = 0;
      for (int k = 0; k < DW; k++) if (re0[k] !== exp_re[k] || im0[k] !== exp_im[k]) diff++;
      checks++; if (diff !== 0) begin errors++; $display("FAIL bp_buffer: got %0d changed entries expected 0", diff); end
   endtask

   task automatic test_flush();
      int   st;
      smp_t s;
      st = 0;
      for (int k = 0; k < 37; k++) begin
         if (start0) st++;
         if0.in_valid = 1'b1; if0.in_re = 16'h3000 + 16'(k); if0.in_im = 16'h4000 + 16'(k);
         push0(k, 16'h3000 + 16'(k), 16'h4000 + 16'(k));
         @(posedge clk);
      end
      checks++; if (wrc0 !== 6'd37) begin errors++; $display("FAIL flush_pre_count: got %0d expected 37", wrc0); end
      if0.flush = 1'b1; if0.in_valid = 1'b1; if0.in_re = 16'hDEAD; if0.in_im = 16'hBEEF;
      @(posedge clk);
      if0.flush = 1'b0;
      sb_q.delete();
      checks++; if (wrc0 !== 6'd0 || if0.in_ready !== 1'b1) begin errors++; $display("FAIL flush_clear: got cnt=%0d ready=%b expected 0/1", wrc0, if0.in_ready); end
      checks++; if (re0[37] !== exp_re[37]) begin errors++; $display("FAIL flush_no_write: got %h expected %h", re0[37], exp_re[37]); end
      for (int k = 0; k < 63; k++) begin
         if (start0) st++;
         if0.in_valid = 1'b1; if0.in_re = 16'h5000 + 16'(k); if0.in_im = 16'h5800 + 16'(k);
         push0(k, 16'h5000 + 16'(k), 16'h5800 + 16'(k));
         @(posedge clk);
      end
      checks++; if (wrc0 !== 6'd63) begin errors++; $display("FAIL flush_63_count: got %0d expected 63", wrc0); end
      // Flush together with what would be the final handshake.
      if0.flush = 1'b1; if0.in_valid = 1'b1; if0.in_re = 16'h503F; if0.in_im = 16'h583F;
      @(posedge clk);
      if0.flush = 1'b0;
      sb_q.delete();
      checks++; if (start0 !== 1'b0 || if0.in_ready !== 1'b1 || wrc0 !== 6'd0) begin
         errors++; $display("FAIL flush_wins: got start=%b ready=%b cnt=%0d expected 0/1/0", start0, if0.in_ready, wrc0);
      end
      checks++; if (re0[63] !== exp_re[63]) begin errors++; $display("FAIL flush_last_no_write: got %h expected %h", re0[63], exp_re[63]); end
      for (int k = 0; k < DW; k++) begin
         if (start0) st++;
         if0.in_valid = 1'b1; if0.in_re = 16'h6000 + 16'(k); if0.in_im = 16'h7000 + 16'(k);
         push0(k, 16'h6000 + 16'(k), 16'h7000 + 16'(k));
         @(posedge clk);
      end
      if0.in_valid = 1'b0;
      checks++; if (st !== 0) begin errors++; $display("FAIL flush_spurious_start: got %0d expected 0", st); end
      checks++; if (start0 !== 1'b1) begin errors++; $display("FAIL flush_new_start: got %b expected 1", start0); end
      while (sb_q.size() > 0) begin
         s = sb_q.pop_front();
         checks++;
         if (re0[s.idx] !== s.re || im0[s.idx] !== s.im) begin
            errors++;
            $display("FAIL flush_buf[%0d]: got %h/%h expected %h/%h", s.idx, re0[s.idx], im0[s.idx], s.re, s.im);
         end
      end
   endtask

   task automatic test_async_reset();
      int nz;
      repeat (50) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      checks++; if (if0.in_ready !== 1'b0 || start0 !== 1'b0 || done0 !== 1'b0) begin
         errors++; $display("FAIL arst_ctrl: got ready=%b start=%b done=%b expected 0/0/0", if0.in_ready, start0, done0);
      end
      checks++; if (wrc0 !== 6'd0) begin errors++; $display("FAIL arst_wr_count: got %0d expected 0", wrc0); end
      nz = 0;
      for (int k = 0; k < DW; k++) if (re0[k] !== 16'h0 || im0[k] !== 16'h0) nz++;
      checks++; if (nz !== 0) begin errors++; $display("FAIL arst_buffer: got %0d nonzero entries expected 0", nz); end
      repeat (2) @(posedge clk);
      checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL arst_hold_done: got %b expected 0", done0); end
      rst = 1'b1;
      #1;
      checks++; if (if0.in_ready !== 1'b0) begin errors++; $display("FAIL arst_idle: got %b expected 0", if0.in_ready); end
      @(posedge clk);
      checks++; if (if0.in_ready !== 1'b1 || done0 !== 1'b0) begin
         errors++; $display("FAIL arst_refill: got ready=%b done=%b expected 1/0", if0.in_ready, done0);
      end
   endtask

   task automatic test_back_to_back();
      int   s1;
      int   s2;
      int   dones0;
      smp_t s;
      s1 = -1; s2 = -1; dones0 = 0;
      sb_q.delete();
      for (int c = 0; c < 300; c++) begin
         if (done0) dones0++;
         if (start1) begin
            if (s1 < 0) s1 = c; else s2 = c;
            while (sb_q.size() > 0) begin
               s = sb_q.pop_front();
               checks++;
               if (re1[s.idx] !== s.re || im1[s.idx] !== s.im) begin
                  errors++;
                  $display("FAIL b2b_buf[%0d]: got %h/%h expected %h/%h", s.idx, re1[s.idx], im1[s.idx], s.re, s.im);
               end
            end
            if (s2 >= 0) break;
         end
         if1.in_valid = 1'b1;
         if1.in_re    = 16'(c);
         if1.in_im    = ~16'(c);
         if (c < 64) begin
            s.idx = c; s.re = 16'(c); s.im = ~16'(c); sb_q.push_back(s);
         end else if (c >= 67 && c < 131) begin
            s.idx = c - 67; s.re = 16'(c); s.im = ~16'(c); sb_q.push_back(s);
         end
         @(posedge clk);
      end
      if1.in_valid = 1'b0;
      checks++; if (s1 !== 64) begin errors++; $display("FAIL b2b_first_start: got %0d expected 64", s1); end
      checks++; if (s2 - s1 !== 67) begin errors++; $display("FAIL b2b_spacing: got %0d expected 67", s2 - s1); end
      checks++; if (dones0 !== 0) begin errors++; $display("FAIL arst_no_done: got %0d expected 0", dones0); end
   endtask

   initial begin
      rst          = 1'b0;
      if0.in_valid = 1'b0; if0.in_re = '0; if0.in_im = '0; if0.flush = 1'b0;
      if1.in_valid = 1'b0; if1.in_re = '0; if1.in_im = '0; if1.flush = 1'b0;
      test_reset();
      test_basic_frame();
      test_gapped_input();
      test_backpressure();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
